// File: rtl/rdl_reg_responder.sv
// Register-file bus responder: accepts one request at a time, decodes it to
// per-register read/write strobes and returns a registered response.
module rdl_reg_responder #(
    parameter int                   DW           = 32,
    parameter int                   AW           = 12,
    parameter int                   NumRegs      = 8,
    parameter logic [NumRegs-1:0]   ReadOnlyMask = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [AW-1:0]           req_addr,
    input  logic [DW-1:0]           req_wdata,
    input  logic [DW/8-1:0]         req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DW-1:0]           rsp_rdata,
    output logic                    rsp_error,
    output logic [NumRegs-1:0]      reg_we,
    output logic [DW-1:0]           reg_wd,
    output logic [NumRegs-1:0]      reg_re,
    input  logic [NumRegs*DW-1:0]   reg_qs
);

    localparam int BW   = DW / 8;
    localparam int OFFW = (BW > 1) ? $clog2(BW) : 0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]         state;
    logic               cap_write;
    logic [AW-1:0]      cap_addr;
    logic [DW-1:0]      cap_wdata;
    logic [BW-1:0]      cap_wstrb;

    logic [AW-1:0]      word_index;
    logic [31:0]        index_ext;
    logic               misaligned;
    logic               in_range;
    logic [NumRegs-1:0] hit;
    logic [DW-1:0]      sel_qs;
    logic [DW-1:0]      merged;
    logic               ro_hit;
    logic               access_err;
    logic               in_access;

    assign word_index = cap_addr >> OFFW;
    assign index_ext  = 32'(word_index);
    assign misaligned = (cap_addr & AW'(BW - 1)) != '0;
    assign in_range   = index_ext < 32'(NumRegs);

    // hit is one-hot by construction: at most one index can match.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        hit    = '0;
        sel_qs = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (!misaligned && in_range && index_ext == 32'(i)) begin
                hit[i] = 1'b1;
                sel_qs = reg_qs[i*DW +: DW];
            end
        end
    end

    always_comb begin
        merged = '0;
        for (int b = 0; b < BW; b++) begin
            merged[b*8 +: 8] = cap_wstrb[b] ? cap_wdata[b*8 +: 8] : sel_qs[b*8 +: 8];
        end
    end

    assign ro_hit     = |(hit & ReadOnlyMask);
    assign access_err = misaligned || !in_range || (cap_write && ro_hit);
    assign in_access  = (state == ACCESS);

    assign reg_re = (in_access && !cap_write) ? hit : '0;
    assign reg_we = (in_access && cap_write && !ro_hit && |cap_wstrb) ? hit : '0;
    assign reg_wd = (in_access && cap_write && !access_err) ? merged : '0;

    // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_wstrb <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        cap_write <= req_write;
                        cap_addr  <= req_addr;
                        cap_wdata <= req_wdata;
                        cap_wstrb <= req_wstrb;
                        req_ready <= 1'b0;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    rsp_valid <= 1'b1;
                    rsp_error <= access_err;
                    rsp_rdata <= (!cap_write && !access_err) ? sel_qs : '0;
                    state     <= RESP;
                end
                RESP: begin
                    // req_ready comes back from the flop, never from rsp_ready directly.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rdl_reg_responder.sv
// Directed bench for rdl_reg_responder: reads, merged writes, error cases,
// response backpressure and reset in the middle of a transaction.
module tb_rdl_reg_responder;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int NR = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic [DW/8-1:0]   req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_error;
    logic [NR-1:0]     reg_we;
    logic [DW-1:0]     reg_wd;
    logic [NR-1:0]     reg_re;
    logic [NR*DW-1:0]  reg_qs;
    logic [DW-1:0]     qs [NR];

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int onehot_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) reg_qs[i*DW +: DW] = qs[i];
    end

    rdl_reg_responder #(
        .DW(DW), .AW(AW), .NumRegs(NR), .ReadOnlyMask(8'b0000_1000)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .reg_we(reg_we), .reg_wd(reg_wd), .reg_re(reg_re), .reg_qs(reg_qs)
    );

    // Strobe-cycle counters, sampled just before each edge.
    always @(posedge clk) begin
        if (!rst) begin
            if (reg_we != '0) we_cnt++;
            if (reg_re != '0) re_cnt++;
            if ($countones(reg_we) > 1 || $countones(reg_re) > 1) onehot_bad++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [3:0] wstrb, input int hold,
                           input logic [NR-1:0] exp_we, input logic [NR-1:0] exp_re,
                           input logic [DW-1:0] exp_wd, input logic [DW-1:0] exp_rdata,
                           input logic exp_err);
        int we0, re0, n;
        we0 = we_cnt;
        re0 = re_cnt;
        @(negedge clk);
        req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_reg_we"}, 64'(reg_we), 64'(exp_we));
        check({tag, "_reg_re"}, 64'(reg_re), 64'(exp_re));
        check({tag, "_reg_wd"}, 64'(reg_wd), 64'(exp_wd));
        check({tag, "_rsp_valid_n1"}, 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check({tag, "_rsp_valid_n2"}, 64'(rsp_valid), 64'd1);
        check({tag, "_strobes_resp"}, 64'({reg_we, reg_re}), 64'd0);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = '0;
            req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
            check({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
            check({tag, "_hold_rsp_valid"}, 64'(rsp_valid), 64'd1);
            check({tag, "_hold_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
            @(negedge clk);
        end
        req_valid = 1'b0;
        check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(exp_rdata));
        check({tag, "_rsp_error"}, 64'(rsp_error), 64'(exp_err));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_valid_done"}, 64'(rsp_valid), 64'd0);
        check({tag, "_req_ready_done"}, 64'(req_ready), 64'd1);
        check({tag, "_we_pulses"}, 64'(we_cnt - we0), (exp_we != '0) ? 64'd1 : 64'd0);
        check({tag, "_re_pulses"}, 64'(re_cnt - re0), (exp_re != '0) ? 64'd1 : 64'd0);
    endtask

    initial begin
        int s_we, s_re;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NR; i++) qs[i] = 32'h0;
        qs[1] = 32'hAABBCCDD;
        qs[2] = 32'hCAFE0001;
        qs[3] = 32'h33333333;
        qs[5] = 32'h12345678;
        qs[7] = 32'h77777777;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_error", 64'(rsp_error), 64'd0);
        check("rst_strobes", 64'({reg_we, reg_re}), 64'd0);
        check("rst_reg_wd", 64'(reg_wd), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 64'(req_ready), 64'd1);

        //      tag        wr    addr     wdata         wstrb  hold exp_we        exp_re        exp_wd        exp_rdata     err
        run_txn("rd2",     1'b0, 12'h008, 32'h0,        4'h0,  0,   8'b0,         8'b0000_0100, 32'h0,        32'hCAFE0001, 1'b0);
        run_txn("wr1",     1'b1, 12'h004, 32'h11223344, 4'h5,  0,   8'b0000_0010, 8'b0,         32'hAA22CC44, 32'h0,        1'b0);
        run_txn("wr_ro3",  1'b1, 12'h00C, 32'h55555555, 4'hF,  0,   8'b0,         8'b0,         32'h0,        32'h0,        1'b1);
        run_txn("rd_mis",  1'b0, 12'h002, 32'h0,        4'h0,  0,   8'b0,         8'b0,         32'h0,        32'h0,        1'b1);
        run_txn("rd_oor",  1'b0, 12'h020, 32'h0,        4'h0,  0,   8'b0,         8'b0,         32'h0,        32'h0,        1'b1);
        run_txn("wr_nostb",1'b1, 12'h000, 32'h99999999, 4'h0,  0,   8'b0,         8'b0,         32'h0,        32'h0,        1'b0);
        run_txn("wr7_full",1'b1, 12'h01C, 32'h0BADF00D, 4'hF,  0,   8'b1000_0000, 8'b0,         32'h0BADF00D, 32'h0,        1'b0);
        run_txn("rd5_bp",  1'b0, 12'h014, 32'h0,        4'h0,  5,   8'b0,         8'b0010_0000, 32'h0,        32'h12345678, 1'b0);

        // Reset while the request is in ACCESS.
        @(negedge clk);
        req_write = 1'b0; req_addr = 12'h008; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rstacc_reg_re_pre", 64'(reg_re), 64'h4);
        rst = 1'b1;
        #1;
        check("rstacc_reg_re", 64'(reg_re), 64'd0);
        check("rstacc_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rstacc_req_ready", 64'(req_ready), 64'd0);
        s_we = we_cnt; s_re = re_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstacc_req_ready_after", 64'(req_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("rstacc_no_strobes", 64'({32'(we_cnt - s_we), 32'(re_cnt - s_re)}), 64'd0);
        run_txn("rstacc_rd", 1'b0, 12'h008, 32'h0, 4'h0, 0, 8'b0, 8'b0000_0100, 32'h0, 32'hCAFE0001, 1'b0);

        // Reset while the response is waiting in RESP.
        @(negedge clk);
        req_write = 1'b1; req_addr = 12'h004; req_wdata = 32'h01020304; req_wstrb = 4'hF;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rstrsp_rsp_valid_pre", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rstrsp_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rstrsp_rsp_error", 64'(rsp_error), 64'd0);
        s_we = we_cnt; s_re = re_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstrsp_req_ready_after", 64'(req_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("rstrsp_no_strobes", 64'({32'(we_cnt - s_we), 32'(re_cnt - s_re)}), 64'd0);
        run_txn("rstrsp_rd", 1'b0, 12'h014, 32'h0, 4'h0, 0, 8'b0, 8'b0010_0000, 32'h0, 32'h12345678, 1'b0);

        check("onehot_strobes", 64'(onehot_bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
